// File: rtl/socket_pkg.sv
// Shared types and helpers for the socket arbiter.
// Holds the arbiter FSM states and an index-width function.
package socket_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_PULL
  } t_arb_state;

  // $clog2 that never returns zero, so a 1-entry range
  // still gets a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/counter.sv
// Generic up-counter with synchronous clear.
// Ports: i_clk, i_rst (sync, high), i_init (clear), i_dv (count), o_count.
module counter #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_init,
  input  logic             i_dv,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_init) begin
      r_count <= '0;
    end else if (i_dv) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/round_robin_picker.sv
// Combinational round-robin search starting after i_last.
// Ports: i_req (requests), i_last (previous grant), o_found, o_index.
module round_robin_picker
  import socket_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = idx_width(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_last,
  output logic         o_found,
  output logic [W-1:0] o_index
);

  int w_cand;

  // Offsets 1..N visit every port once, ending on i_last
  // itself, so the previous winner has lowest priority.
  always_comb begin
    o_found = 1'b0;
    o_index = '0;
    w_cand  = 0;
    for (int k = 1; k <= N; k++) begin
      w_cand = (int'(i_last) + k) % N;
      if (!o_found && i_req[w_cand[W-1:0]]) begin
        o_found = 1'b1;
        o_index = w_cand[W-1:0];
      end
    end
  end

endmodule

// File: rtl/socket_arbiter.sv
// Round-robin burst arbiter: N FIFOs share one downstream socket.
// Ports: i_full/i_empty/i_data per FIFO, i_ready; o_rd_en, o_data, o_dv, o_sof, o_eof, o_port, o_underflow.
module socket_arbiter
  import socket_pkg::*;
#(
  parameter  int N_PORTS    = 4,
  parameter  int FRAME_LEN  = 4,
  parameter  int DATA_WIDTH = 8,
  localparam int PW         = idx_width(N_PORTS),
  localparam int BW         = idx_width(FRAME_LEN)
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [N_PORTS-1:0]            i_full,
  input  logic [N_PORTS-1:0]            i_empty,
  input  logic [N_PORTS*DATA_WIDTH-1:0] i_data,
  input  logic                          i_ready,
  output logic [N_PORTS-1:0]            o_rd_en,
  output logic [DATA_WIDTH-1:0]         o_data,
  output logic                          o_dv,
  output logic                          o_sof,
  output logic                          o_eof,
  output logic [PW-1:0]                 o_port,
  output logic                          o_underflow
);

  t_arb_state r_state;
  t_arb_state w_next;

  logic [N_PORTS-1:0]    w_elig;
  logic                  w_found;
  logic [PW-1:0]         w_pick;
  logic [PW-1:0]         r_grant;
  logic [PW-1:0]         r_last;
  logic [BW-1:0]         w_beat;
  logic                  w_idle;
  logic                  w_pull;
  logic                  w_start;
  logic                  w_last_beat;

  logic                  r_rd_d;
  logic [BW-1:0]         r_beat_d;
  logic [PW-1:0]         r_grant_d;

  logic [DATA_WIDTH-1:0] w_word;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_dv;
  logic                  r_sof;
  logic                  r_eof;
  logic [PW-1:0]         r_port;
  logic                  r_uf;

  assign w_elig = i_full & ~i_empty;
  assign w_idle = (r_state == ST_IDLE);

  round_robin_picker #(
    .N(N_PORTS)
  ) u_pick (
    .i_req   (w_elig),
    .i_last  (r_last),
    .o_found (w_found),
    .o_index (w_pick)
  );

  counter #(
    .WIDTH(BW)
  ) u_beat (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_init  (w_idle),
    .i_dv    (w_pull),
    .o_count (w_beat)
  );

  assign w_last_beat = (w_beat == BW'(FRAME_LEN - 1));
  // i_ready only matters here; a started burst never stalls.
  assign w_start = w_idle && i_ready && w_found;

  always_comb begin
    w_next  = r_state;
    o_rd_en = '0;
    w_pull  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start) w_next = ST_PULL;
      end
      ST_PULL: begin
        o_rd_en[r_grant] = 1'b1;
        w_pull           = 1'b1;
        if (w_last_beat) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_last  <= PW'(N_PORTS - 1);
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_grant <= w_pick;
        r_last  <= w_pick;
      end
    end
  end

  // FIFO data lags rd_en by one cycle; this stage
  // lines the beat tags up with it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_d    <= 1'b0;
      r_beat_d  <= '0;
      r_grant_d <= '0;
    end else begin
      r_rd_d    <= w_pull;
      r_beat_d  <= w_beat;
      r_grant_d <= r_grant;
    end
  end

  always_comb begin
    w_word = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (r_grant_d == PW'(p)) begin
        w_word = i_data[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data <= '0;
      r_dv   <= 1'b0;
      r_sof  <= 1'b0;
      r_eof  <= 1'b0;
      r_port <= '0;
      r_uf   <= 1'b0;
    end else begin
      r_dv  <= r_rd_d;
      r_sof <= r_rd_d && (r_beat_d == '0);
      r_eof <= r_rd_d && (r_beat_d == BW'(FRAME_LEN - 1));
      if (r_rd_d) begin
        r_data <= w_word;
        r_port <= r_grant_d;
      end
      if (w_pull && i_empty[r_grant]) begin
        r_uf <= 1'b1;
      end
    end
  end

  assign o_data      = r_data;
  assign o_dv        = r_dv;
  assign o_sof       = r_sof;
  assign o_eof       = r_eof;
  assign o_port      = r_port;
  assign o_underflow = r_uf;

endmodule

// File: tb/tb_socket_arbiter.sv
// Self-checking bench for socket_arbiter.
// Behavioural FIFO environment plus a round-robin reference model.
module tb_socket_arbiter;

  localparam int N  = 4;
  localparam int FL = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          ready;
  logic [N-1:0]  full;
  logic [N-1:0]  empty;
  logic [N-1:0]  rd_en;
  logic [N*DW-1:0] idata;
  logic [DW-1:0] odata;
  logic          dv;
  logic          sof;
  logic          eof;
  logic          uf;
  logic [1:0]    oport;

  int errors = 0;
  int checks = 0;

  socket_arbiter #(
    .N_PORTS    (N),
    .FRAME_LEN  (FL),
    .DATA_WIDTH (DW)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_full      (full),
    .i_empty     (empty),
    .i_data      (idata),
    .i_ready     (ready),
    .o_rd_en     (rd_en),
    .o_data      (odata),
    .o_dv        (dv),
    .o_sof       (sof),
    .o_eof       (eof),
    .o_port      (oport),
    .o_underflow (uf)
  );

  // upstream FIFO environment
  logic [DW-1:0] mem [N][FL];
  int            rptr [N];
  bit            loaded [N];
  logic [N-1:0]  force_empty;
  logic [N-1:0]  fill_mask;
  bit            rand_fill;

  // reference model
  typedef struct {
    bit            v;
    int            p;
    int            beat;
    logic [DW-1:0] d;
  } beat_t;

  beat_t m_cur, m_d1, m_d2;
  int    m_rem;
  int    m_last;
  bit    m_uf;
  logic [N-1:0] exp_rd;

  task automatic update_flags();
    for (int p = 0; p < N; p++) begin
      full[p]  = loaded[p] && (rptr[p] == 0);
      empty[p] = !loaded[p] || force_empty[p];
    end
  endtask

  task automatic load(input int p, input bit seq,
                      input logic [DW-1:0] base);
    for (int k = 0; k < FL; k++) begin
      mem[p][k] = seq ? base + DW'(k) : DW'($urandom);
    end
    rptr[p]   = 0;
    loaded[p] = 1'b1;
  endtask

  task automatic env_clear();
    for (int p = 0; p < N; p++) begin
      loaded[p] = 1'b0;
      rptr[p]   = 0;
    end
    force_empty = '0;
    fill_mask   = '0;
    rand_fill   = 1'b0;
    update_flags();
  endtask

  function automatic int rr_pick(input logic [N-1:0] el,
                                 input int last);
    for (int k = 1; k <= N; k++) begin
      if (el[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  // One clock: advance model and environment, return at #1.
  task automatic step();
    logic [N-1:0] rd_prev;
    logic [N-1:0] elig;
    bit rdy, rs, uf_pend;
    int g;
    rd_prev = rd_en;
    elig    = full & ~empty;
    rdy     = ready;
    rs      = rst;
    uf_pend = m_cur.v && empty[m_cur.p];
    @(posedge clk);
    #1;
    m_d2 = m_d1;
    m_d1 = m_cur;
    if (rs) begin
      m_rem  = 0;
      m_last = N - 1;
      m_uf   = 1'b0;
      m_d1   = '{0, 0, 0, '0};
      m_d2   = '{0, 0, 0, '0};
    end else begin
      if (uf_pend) m_uf = 1'b1;
      if (m_rem > 0) begin
        m_rem--;
      end else if (rdy) begin
        g = rr_pick(elig, m_last);
        if (g >= 0) begin
          m_cur.p = g;
          m_last  = g;
          m_rem   = FL;
        end
      end
    end
    if (!rs && m_rem > 0) begin
      m_cur.v    = 1'b1;
      m_cur.beat = FL - m_rem;
      m_cur.d    = mem[m_cur.p][m_cur.beat];
    end else begin
      m_cur = '{0, 0, 0, '0};
    end
    exp_rd = m_cur.v ? (N'(1) << m_cur.p) : '0;
    for (int p = 0; p < N; p++) begin
      if (rd_prev[p] && loaded[p]) begin
        idata[p*DW +: DW] = mem[p][rptr[p]];
        rptr[p]++;
        if (rptr[p] == FL) begin
          loaded[p] = 1'b0;
          rptr[p]   = 0;
        end
      end
      if (!loaded[p] && (fill_mask[p] ||
          (rand_fill && $urandom_range(0, 3) == 0))) begin
        load(p, 1'b0, '0);
      end
    end
    update_flags();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    env_clear();
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    ready = 1'b1;
    load(0, 1'b1, 8'h55);
    update_flags();
    step();
    step();
    if (rd_en !== 4'b0000) begin
      errors++;
      $display("FAIL reset_rd_en got=%b want=0000", rd_en);
    end
    checks++;
    if ({dv, sof, eof} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got=%b want=000", {dv, sof, eof});
    end
    checks++;
    if (odata !== 8'h00 || oport !== 2'd0) begin
      errors++;
      $display("FAIL reset_data got=%h/%0d want=00/0",
               odata, oport);
    end
    checks++;
    if (uf !== 1'b0) begin
      errors++;
      $display("FAIL reset_uf got=%b want=0", uf);
    end
    checks++;
    rst = 1'b0;
    step();
    if (rd_en !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_grant got=%b want=0001", rd_en);
    end
    checks++;
    for (int i = 0; i < 8; i++) step();
    do_reset();
  endtask

  task automatic test_single_port();
    logic [DW-1:0] qd[$];
    int qp[$], qs[$], qe[$];
    int first_rd, first_dv, rd_cnt;
    logic [DW-1:0] w;
    first_rd = -1;
    first_dv = -1;
    rd_cnt   = 0;
    do_reset();
    ready = 1'b1;
    load(2, 1'b1, 8'h10);
    update_flags();
    for (int i = 1; i <= 12; i++) begin
      step();
      if (rd_en !== exp_rd) begin
        errors++;
        $display("FAIL single_rd cyc=%0d got=%b want=%b",
                 i, rd_en, exp_rd);
      end
      checks++;
      if (rd_en == 4'b0100) rd_cnt++;
      if (rd_en != 0 && first_rd < 0) first_rd = i;
      if (dv === 1'b1) begin
        if (first_dv < 0) first_dv = i;
        qd.push_back(odata);
        qp.push_back(int'(oport));
        qs.push_back(int'(sof));
        qe.push_back(int'(eof));
      end
    end
    if (first_rd != 1 || first_dv != 3 || rd_cnt != 4) begin
      errors++;
      $display("FAIL single_timing got=%0d/%0d/%0d want=1/3/4",
               first_rd, first_dv, rd_cnt);
    end
    checks++;
    if (qd.size() != 4) begin
      errors++;
      $display("FAIL single_count got=%0d want=4", qd.size());
    end
    checks++;
    for (int k = 0; k < 4 && k < qd.size(); k++) begin
      w = 8'h10 + DW'(k);
      if (qd[k] !== w || qp[k] != 2 ||
          qs[k] != int'(k == 0) || qe[k] != int'(k == 3)) begin
        errors++;
        $display("FAIL single_word k=%0d got=%h p%0d s%0d e%0d want=%h p2 s%0d e%0d",
                 k, qd[k], qp[k], qs[k], qe[k],
                 w, int'(k == 0), int'(k == 3));
      end
      checks++;
    end
  endtask

  task automatic test_fairness();
    int gr[4];
    int n;
    logic [N-1:0] prev;
    int want[4];
    want = '{0, 3, 0, 3};
    gr   = '{-1, -1, -1, -1};
    n    = 0;
    prev = '0;
    do_reset();
    ready     = 1'b1;
    fill_mask = 4'b1001;
    load(0, 1'b0, '0);
    load(3, 1'b0, '0);
    update_flags();
    for (int i = 0; i < 60 && n < 4; i++) begin
      step();
      if (rd_en !== exp_rd) begin
        errors++;
        $display("FAIL fair_rd got=%b want=%b", rd_en, exp_rd);
      end
      checks++;
      if (rd_en != 0 && prev == 0) begin
        for (int p = 0; p < N; p++) if (rd_en[p]) gr[n] = p;
        n++;
      end
      prev = rd_en;
    end
    for (int k = 0; k < 4; k++) begin
      if (gr[k] != want[k]) begin
        errors++;
        $display("FAIL fair_grant k=%0d got=%0d want=%0d",
                 k, gr[k], want[k]);
      end
      checks++;
    end
    fill_mask = '0;
    for (int i = 0; i < 12; i++) step();
  endtask

  task automatic test_wrap();
    int gr[2];
    int n;
    logic [N-1:0] prev;
    gr   = '{-1, -1};
    n    = 0;
    prev = '0;
    do_reset();
    ready = 1'b1;
    load(3, 1'b0, '0);
    update_flags();
    for (int i = 0; i < 8; i++) step();
    load(1, 1'b0, '0);
    load(2, 1'b0, '0);
    update_flags();
    for (int i = 0; i < 30 && n < 2; i++) begin
      step();
      if (rd_en != 0 && prev == 0) begin
        for (int p = 0; p < N; p++) if (rd_en[p]) gr[n] = p;
        n++;
      end
      prev = rd_en;
    end
    if (gr[0] != 1 || gr[1] != 2) begin
      errors++;
      $display("FAIL wrap_grants got=%0d,%0d want=1,2",
               gr[0], gr[1]);
    end
    checks++;
    for (int i = 0; i < 8; i++) step();
  endtask

  task automatic test_ready_low();
    do_reset();
    ready = 1'b0;
    load(1, 1'b0, '0);
    update_flags();
    for (int i = 0; i < 6; i++) begin
      step();
      if (rd_en !== 4'b0000) begin
        errors++;
        $display("FAIL ready_low_rd cyc=%0d got=%b want=0000",
                 i, rd_en);
      end
      checks++;
    end
    ready = 1'b1;
    step();
    if (rd_en !== 4'b0010) begin
      errors++;
      $display("FAIL ready_rise_rd got=%b want=0010", rd_en);
    end
    checks++;
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (rd_en !== 4'b0010) begin
        errors++;
        $display("FAIL ready_midburst_rd got=%b want=0010", rd_en);
      end
      checks++;
    end
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    ready = 1'b1;
    load(1, 1'b0, '0);
    update_flags();
    for (int i = 0; i < 10 && rd_en == 0; i++) step();
    if (rd_en !== 4'b0010) begin
      errors++;
      $display("FAIL midrst_start got=%b want=0010", rd_en);
    end
    checks++;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    if (rd_en !== 4'b0000 || dv !== 1'b0) begin
      errors++;
      $display("FAIL midrst_clear got=%b/%b want=0000/0",
               rd_en, dv);
    end
    checks++;
    env_clear();
    load(0, 1'b0, '0);
    load(2, 1'b0, '0);
    update_flags();
    step();
    if (rd_en !== 4'b0001 || dv !== 1'b0) begin
      errors++;
      $display("FAIL midrst_regrant got=%b/%b want=0001/0",
               rd_en, dv);
    end
    checks++;
    step();
    if (dv !== 1'b0) begin
      errors++;
      $display("FAIL midrst_flush got=%b want=0", dv);
    end
    checks++;
    for (int i = 0; i < 14; i++) step();
  endtask

  task automatic test_underflow();
    do_reset();
    ready = 1'b1;
    load(0, 1'b0, '0);
    update_flags();
    for (int i = 0; i < 10 && rd_en == 0; i++) step();
    step();
    step();
    if (uf !== 1'b0 || rd_en !== 4'b0001) begin
      errors++;
      $display("FAIL uf_before got=%b/%b want=0/0001", uf, rd_en);
    end
    checks++;
    force_empty[0] = 1'b1;
    update_flags();
    step();
    force_empty[0] = 1'b0;
    update_flags();
    if (uf !== 1'b1 || rd_en !== 4'b0001) begin
      errors++;
      $display("FAIL uf_set got=%b/%b want=1/0001", uf, rd_en);
    end
    checks++;
    step();
    if (rd_en !== 4'b0000) begin
      errors++;
      $display("FAIL uf_burst_end got=%b want=0000", rd_en);
    end
    checks++;
    for (int i = 0; i < 10; i++) step();
    if (uf !== 1'b1) begin
      errors++;
      $display("FAIL uf_sticky got=%b want=1", uf);
    end
    checks++;
    do_reset();
    if (uf !== 1'b0) begin
      errors++;
      $display("FAIL uf_clear got=%b want=0", uf);
    end
    checks++;
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    do_reset();
    rand_fill = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      ready = ($urandom_range(0, 3) != 0);
      step();
      if (rd_en !== exp_rd) begin
        errors++;
        bad++;
        if (bad < 10)
          $display("FAIL rand_rd cyc=%0d got=%b want=%b",
                   i, rd_en, exp_rd);
      end
      checks++;
      if (dv !== m_d2.v) begin
        errors++;
        bad++;
        if (bad < 10)
          $display("FAIL rand_dv cyc=%0d got=%b want=%b",
                   i, dv, m_d2.v);
      end
      checks++;
      if (m_d2.v && (odata !== m_d2.d ||
          int'(oport) != m_d2.p ||
          sof !== (m_d2.beat == 0) ||
          eof !== (m_d2.beat == FL - 1))) begin
        errors++;
        bad++;
        if (bad < 10)
          $display("FAIL rand_word cyc=%0d got=%h p%0d s%b e%b want=%h p%0d beat%0d",
                   i, odata, oport, sof, eof,
                   m_d2.d, m_d2.p, m_d2.beat);
      end
      checks++;
      if (uf !== m_uf) begin
        errors++;
        bad++;
        if (bad < 10)
          $display("FAIL rand_uf cyc=%0d got=%b want=%b",
                   i, uf, m_uf);
      end
      checks++;
    end
  endtask

  initial begin
    rst    = 1'b1;
    ready  = 1'b0;
    idata  = '0;
    m_rem  = 0;
    m_last = N - 1;
    m_uf   = 1'b0;
    m_cur  = '{0, 0, 0, '0};
    m_d1   = '{0, 0, 0, '0};
    m_d2   = '{0, 0, 0, '0};
    exp_rd = '0;
    env_clear();
    test_reset();
    test_single_port();
    test_fairness();
    test_wrap();
    test_ready_low();
    test_reset_mid();
    test_underflow();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
